// File: rtl/riscv_rf_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_rf_pkg
//  Purpose  : Shared register-file geometry for the GPR write-back path.
//  Revision : 1.0  initial release
// ============================================================================
package riscv_rf_pkg;
    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NREG = 32;

    typedef logic [AW-1:0] reg_idx_t;

    localparam reg_idx_t X0 = '0;
endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Combinational round-robin grant: first valid at or above ptr.
//  Revision : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int NREQ = 3,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] valid,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   grant_idx,
    output logic            grant_valid
);

    logic [PW-1:0] w_idx;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        w_idx       = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = PW'((int'(ptr) + k) % NREQ);
            if (!grant_valid && valid[w_idx]) begin
                grant_valid  = 1'b1;
                grant_idx    = w_idx;
                grant[w_idx] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_wb_arbiter
//  Purpose  : Round-robin sharing of the GPR write port with a registered
//             output stage; WB_SCOREBOARD_EN adds a busy-register hazard flag.
//  Revision : 1.0  initial release
// ============================================================================
module regfile_wb_arbiter
    import riscv_rf_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int XLEN = riscv_rf_pkg::XLEN,
    parameter int AW   = riscv_rf_pkg::AW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*XLEN-1:0] req_data,
    output logic                 rf_write_enable,
    output logic [AW-1:0]        rf_write_addr,
    output logic [XLEN-1:0]      rf_write_data,
    input  logic                 issue_valid,
    input  logic [AW-1:0]        issue_rd,
    input  logic [AW-1:0]        chk_rs1,
    input  logic [AW-1:0]        chk_rs2,
    input  logic [AW-1:0]        chk_rd,
    output logic                 hazard
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   r_ptr;
    logic [NREQ-1:0] w_grant;
    logic [PW-1:0]   w_gidx;
    logic            w_gvalid;
    logic            w_xfer;
    logic [AW-1:0]   w_sel_addr;
    logic [XLEN-1:0] w_sel_data;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_arbiter (
        .valid       (req_valid),
        .ptr         (r_ptr),
        .grant       (w_grant),
        .grant_idx   (w_gidx),
        .grant_valid (w_gvalid)
    );

    // Ready is suppressed during reset so nothing transfers while the stage clears.
    assign req_ready  = rst ? '0 : w_grant;
    assign w_xfer     = w_gvalid & ~rst;
    assign w_sel_addr = req_addr[int'(w_gidx)*AW +: AW];
    assign w_sel_data = req_data[int'(w_gidx)*XLEN +: XLEN];

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_write_enable <= 1'b0;
            rf_write_addr   <= '0;
            rf_write_data   <= '0;
            r_ptr           <= '0;
        end else if (w_xfer) begin
            rf_write_enable <= (w_sel_addr != X0);
            rf_write_addr   <= w_sel_addr;
            rf_write_data   <= w_sel_data;
            r_ptr           <= (w_gidx == PW'(NREQ-1)) ? '0 : w_gidx + 1'b1;
        end else begin
            rf_write_enable <= 1'b0;
        end
    end

`ifdef WB_SCOREBOARD_EN
    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_next;

    // Clear is applied before set so a same-cycle issue to the committing reg stays busy.
    always_comb begin
        w_busy_next = r_busy;
        if (rf_write_enable)
            w_busy_next[rf_write_addr] = 1'b0;
        if (issue_valid && (issue_rd != X0))
            w_busy_next[issue_rd] = 1'b1;
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_busy <= '0;
        else
            r_busy <= w_busy_next;
    end

    assign hazard = r_busy[chk_rs1] | r_busy[chk_rs2] | r_busy[chk_rd];
`else
    logic w_unused_sb;
    assign w_unused_sb = ^{issue_valid, issue_rd, chk_rs1, chk_rs2, chk_rd};
    assign hazard      = 1'b0;
`endif

endmodule
`default_nettype wire
